ps2_key_tracker: RTL and testbench

Parametrised key-state tracker that consumes the raw PS/2 scan-code byte stream (set 2) from the PS/2 receiver. It decodes make, break (0xF0) and extended (0xE0) sequences, and maintains a held/released bit for each of N_KEYS configurable codes. Per key it produces press/release edge pulses and a programmable auto-repeat pulse. It sits between the PS/2 receiver and game logic, and replaces the fixed four-direction move decoder.

---
 rtl/ps2_key_tracker.sv | 143 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code decoder and per-key held/edge/auto-repeat tracker.
// Sits between the PS/2 receiver and game logic; keys are selected by KEY_CODES.
module ps2_key_tracker #(
    parameter int unsigned            N_KEYS         = 4,
    parameter logic [9*N_KEYS-1:0]    KEY_CODES      = {9'h023, 9'h01C, 9'h01B, 9'h01D},
    parameter int unsigned            REPEAT_DELAY   = 20_000_000,
    parameter int unsigned            REPEAT_PERIOD  = 4_000_000,
    parameter int unsigned            PREFIX_TIMEOUT = 100_000,
    parameter int unsigned            CNT_W          = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    input  logic              clr_all,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_down
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam bit               REP_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   tcnt;
    logic               is_junk;
    logic               ev_make, ev_brk;
    logic [8:0]         ev_code;
    logic [N_KEYS-1:0]  hit, down_nx, pressing, releasing;
    logic [CNT_W-1:0]   rep_cnt [N_KEYS];
    logic [N_KEYS-1:0]  rep_periodic;

    assign is_junk = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ev_make  = 1'b0;
        ev_brk   = 1'b0;
        ev_code  = {1'b0, rx_data};
        if (clr_all || rx_err) begin
            state_nx = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hE0)      state_nx = EXT;
                    else if (rx_data == 8'hF0) state_nx = BRK;
                    else                       ev_make  = !is_junk;
                end
                EXT: begin
                    if (rx_data == 8'hF0)      state_nx = EXT_BRK;
                    else if (rx_data == 8'hE0) state_nx = EXT;
                    else begin
                        ev_make  = 1'b1;
                        ev_code  = {1'b1, rx_data};
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    ev_brk   = 1'b1;
                    state_nx = IDLE;
                end
                EXT_BRK: begin
                    ev_brk   = 1'b1;
                    ev_code  = {1'b1, rx_data};
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && tcnt == TO_LAST) begin
            state_nx = IDLE;
        end
    end

    // tcnt holds the number of cycles since the last accepted byte, so a prefix
    // taken at cycle T expires with the FSM back in IDLE at T+PREFIX_TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst)                                   tcnt <= '0;
        else if (rx_valid && !clr_all && !rx_err)  tcnt <= CNT_W'(1);
        else if (state != IDLE)                    tcnt <= tcnt + CNT_W'(1);
    end

    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++)
            hit[i] = (ev_code == KEY_CODES[9*i +: 9]);
    end

    always_comb begin
        down_nx = key_down;
        if (clr_all) begin
            down_nx = '0;
        end else begin
            if (ev_make) down_nx = down_nx | hit;
            if (ev_brk)  down_nx = down_nx & ~hit;
        end
    end

    assign pressing  = down_nx & ~key_down;
    assign releasing = key_down & ~down_nx;
    assign any_down  = |key_down;

    // Repeat runs only while a key is held across the edge, so neither the
    // press nor the release cycle can ever carry a repeat pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_down     <= '0;
            key_press    <= '0;
            key_release  <= '0;
            key_repeat   <= '0;
            rep_periodic <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) rep_cnt[i] <= '0;
        end else begin
            key_down    <= down_nx;
            key_press   <= pressing;
            key_release <= releasing;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                key_repeat[i] <= 1'b0;
                if (!REP_EN || !(key_down[i] && down_nx[i])) begin
                    rep_cnt[i]      <= '0;
                    rep_periodic[i] <= 1'b0;
                end else if (rep_cnt[i] == (rep_periodic[i] ? PER_LAST : DLY_LAST)) begin
                    key_repeat[i]   <= 1'b1;
                    rep_cnt[i]      <= '0;
                    rep_periodic[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised bench for ps2_key_tracker: event-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ps2_key_tracker;

    localparam int unsigned NK = 4;
    localparam logic [35:0] KC = {9'h174, 9'h023, 9'h01B, 9'h01D};
    localparam int          D  = 10;
    localparam int          R  = 3;
    localparam int          PT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_err = 1'b0;
    logic          clr_all = 1'b0;
    logic [NK-1:0] key_down, key_press, key_release, key_repeat;
    logic          any_down;

    ps2_key_tracker #(
        .N_KEYS(NK), .KEY_CODES(KC), .REPEAT_DELAY(D), .REPEAT_PERIOD(R),
        .PREFIX_TIMEOUT(PT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_err(rx_err), .clr_all(clr_all), .key_down(key_down),
        .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .any_down(any_down)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Model: pending prefix flags with the cycle they arrived, held bits and
    // the press cycle of each key; repeat derived arithmetically from it.
    int          cyc = 0;
    int          tp = 0;
    logic        m_ext = 1'b0, m_brk = 1'b0, model_ok = 1'b0;
    logic [3:0]  m_down = '0;
    int          ptime [NK];
    logic [3:0]  e_down = '0, e_press = '0, e_rel = '0, e_rep = '0;

    always @(posedge clk) begin
        logic [3:0] nd;
        logic       mk, bk;
        logic [8:0] code;
        int         age;
        if (rst) begin
            m_down = '0; e_down = '0; e_press = '0; e_rel = '0; e_rep = '0;
            m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            nd = m_down; mk = 1'b0; bk = 1'b0; code = '0;
            if (clr_all) begin
                nd = '0; m_ext = 1'b0; m_brk = 1'b0;
            end else if (rx_err) begin
                m_ext = 1'b0; m_brk = 1'b0;
            end else if (rx_valid) begin
                if ((m_ext || m_brk) && (cyc - tp >= PT)) begin
                    m_ext = 1'b0; m_brk = 1'b0;
                end
                if (!m_brk && rx_data == 8'hE0) begin
                    m_ext = 1'b1; tp = cyc;
                end else if (!m_brk && rx_data == 8'hF0) begin
                    m_brk = 1'b1; tp = cyc;
                end else if (m_brk) begin
                    bk = 1'b1; code = {m_ext, rx_data}; m_ext = 1'b0; m_brk = 1'b0;
                end else if (m_ext) begin
                    mk = 1'b1; code = {1'b1, rx_data}; m_ext = 1'b0;
                end else if (!(rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
                    mk = 1'b1; code = {1'b0, rx_data};
                end
            end
            for (int i = 0; i < NK; i++) begin
                if (code == KC[9*i +: 9]) begin
                    if (mk) nd[i] = 1'b1;
                    if (bk) nd[i] = 1'b0;
                end
            end
            e_press = nd & ~m_down;
            e_rel   = m_down & ~nd;
            for (int i = 0; i < NK; i++) begin
                if (e_press[i]) ptime[i] = cyc + 1;
                age = cyc + 1 - ptime[i];
                e_rep[i] = nd[i] && m_down[i] && (age >= D) && ((age - D) % R == 0);
            end
            e_down = nd;
            m_down = nd;
        end
        cyc++;
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("key_down",    key_down,          e_down);
            chk("key_press",   key_press,         e_press);
            chk("key_release", key_release,       e_rel);
            chk("key_repeat",  key_repeat,        e_rep);
            chk("any_down",    {3'b000, any_down}, {3'b000, |e_down});
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic e, input logic c);
        @(negedge clk);
        rx_valid = v; rx_data = d; rx_err = e; clr_all = c;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] junk_seq [5];
        int         presses;
        int         r;

        repeat (3) @(negedge clk);
        chk("reset key_down", key_down, 4'b0000);
        chk("reset key_repeat", key_repeat, 4'b0000);
        rst = 1'b0;

        // make then break of key0
        send(8'h1D); idle(1);
        chk("make press", key_press, 4'b0001);
        chk("make down", key_down, 4'b0001);
        send(8'hF0); send(8'h1D); idle(1);
        chk("break release", key_release, 4'b0001);
        chk("break down", key_down, 4'b0000);
        chk("break any_down", {3'b000, any_down}, 4'b0000);

        // extended key3
        send(8'h74); idle(1);
        chk("plain 74", key_down, 4'b0000);
        send(8'hE0); send(8'h74); idle(1);
        chk("ext make", key_down, 4'b1000);
        send(8'hE0); send(8'hF0); send(8'h74); idle(1);
        chk("ext break", key_down, 4'b0000);

        // auto-repeat on key2, released mid-period
        send(8'h23); idle(1);
        chk("repeat press", key_press, 4'b0100);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("repeat k=%0d", k), {3'b000, key_repeat[2]},
                {3'b000, (k == 10 || k == 13) ? 1'b1 : 1'b0});
            if (k == 15) chk("repeat release", key_release, 4'b0100);
            rx_valid = (k == 13 || k == 14);
            rx_data  = (k == 13) ? 8'hF0 : ((k == 14) ? 8'h23 : 8'h00);
        end

        // typematic and junk
        junk_seq[0] = 8'h1D; junk_seq[1] = 8'h1D; junk_seq[2] = 8'h1D;
        junk_seq[3] = 8'hAA; junk_seq[4] = 8'hFA;
        presses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            presses += int'(key_press[0]);
            rx_valid = 1'b1; rx_data = junk_seq[i];
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            presses += int'(key_press[0]);
            rx_valid = 1'b0; rx_data = 8'h00;
        end
        chk("typematic presses", 4'(presses), 4'd1);
        chk("typematic down", key_down, 4'b0001);

        // break prefix expires exactly PT cycles later
        send(8'hF0); idle(PT - 1); send(8'h1D); idle(1);
        chk("timeout no press", key_press, 4'b0000);
        chk("timeout still down", key_down, 4'b0001);
        send(8'hF0); idle(PT - 2); send(8'h1D); idle(1);
        chk("pre-timeout release", key_release, 4'b0001);

        // clr_all beats a same-cycle byte
        send(8'h1D); send(8'h23); idle(1);
        chk("clr setup", key_down, 4'b0101);
        step(1'b1, 8'h1B, 1'b0, 1'b1); idle(1);
        chk("clr release", key_release, 4'b0101);
        chk("clr down", key_down, 4'b0000);
        idle(1);
        chk("clr drop 1B", key_down, 4'b0000);

        // reset mid-sequence
        send(8'hE0);
        @(negedge clk); rx_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midseq rst down", key_down, 4'b0000);
        send(8'h1D); idle(1);
        chk("post-rst plain", key_down, 4'b0001);

        // rx_err drops a pending E0
        send(8'hE0); step(1'b0, 8'h00, 1'b1, 1'b0); send(8'h74); idle(1);
        chk("err drops E0", key_down, 4'b0001);
        send(8'hF0); send(8'h1D); idle(2);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 40) begin
                idle($urandom_range(PT - 3, PT + 3));
            end else begin
                @(negedge clk);
                rst      = ($urandom_range(0, 999) < 3);
                clr_all  = ($urandom_range(0, 99) < 1);
                rx_valid = ($urandom_range(0, 99) < 45);
                rx_err   = !rx_valid && ($urandom_range(0, 99) < 2);
                case ($urandom_range(0, 9))
                    0, 1:    rx_data = 8'hF0;
                    2:       rx_data = 8'hE0;
                    3:       rx_data = 8'h1D;
                    4:       rx_data = 8'h1B;
                    5:       rx_data = 8'h23;
                    6:       rx_data = 8'h74;
                    7:       rx_data = 8'hAA;
                    default: rx_data = 8'($urandom);
                endcase
            end
        end
        @(negedge clk);
        rst = 1'b0; clr_all = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
